// File: rtl/led_fader_pkg.sv
// Shared defaults and brightness helpers for the LED fader.
// The gamma helper is only used when LED_FADER_GAMMA_EN is defined.
package led_fader_pkg;
    localparam int NUM_LEDS_DEF = 10;
    localparam int PWM_BITS_DEF = 8;
    localparam int STEP_DIV_DEF = 50000;

    function automatic int unsigned max_level(input int unsigned bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

    // Squared-level duty; full-on is pinned to MAX so it stays solid.
    function automatic int unsigned gamma_duty(input int unsigned level, input int unsigned bits);
        logic [63:0] sq;
        sq = 64'(level) * 64'(level);
        if (level == max_level(bits))
            return level;
        return 32'(sq >> bits);
    endfunction
endpackage

// File: rtl/led_fader_if.sv
// LED pattern in / PWM drive out bundle between the PIO and the fader.
interface led_fader_if #(
    parameter int NUM_LEDS = led_fader_pkg::NUM_LEDS_DEF
);
    logic [NUM_LEDS-1:0] led_in;
    logic                fade_en;
    logic [NUM_LEDS-1:0] led_out;
    logic                busy;

    modport master (output led_in, fade_en, input led_out, busy);
    modport slave  (input led_in, fade_en, output led_out, busy);
endinterface

// File: rtl/led_fader_channel.sv
// One LED channel: brightness level ramp and registered PWM compare.
// Define LED_FADER_GAMMA_EN for the squared (perceptual) duty curve.
module led_fader_channel
    import led_fader_pkg::*;
#(
    parameter int PWM_BITS = PWM_BITS_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_step_tick,
    input  logic [PWM_BITS-1:0] i_pwm_cnt,
    input  logic                i_target,
    input  logic                i_fade_en,
    output logic                o_led,
    output logic                o_mismatch
);
    localparam logic [PWM_BITS-1:0] MAX = PWM_BITS'(max_level(PWM_BITS));

    logic [PWM_BITS-1:0] r_level;
    logic [PWM_BITS-1:0] w_target;
    logic [PWM_BITS-1:0] w_level_nxt;
    logic [PWM_BITS-1:0] w_duty;

    assign w_target   = i_target ? MAX : '0;
    assign o_mismatch = (r_level != w_target);

`ifdef LED_FADER_GAMMA_EN
    assign w_duty = PWM_BITS'(gamma_duty(32'(r_level), PWM_BITS));
`else
    assign w_duty = r_level;
`endif

    // Bypass snaps to the target so re-enabling fade starts glitch-free.
    always_comb begin
        w_level_nxt = r_level;
        if (!i_fade_en)
            w_level_nxt = w_target;
        else if (i_step_tick) begin
            if (r_level < w_target)
                w_level_nxt = r_level + PWM_BITS'(1);
            else if (r_level > w_target)
                w_level_nxt = r_level - PWM_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_level <= '0;
            o_led   <= 1'b0;
        end else begin
            r_level <= w_level_nxt;
            o_led   <= i_fade_en ? (w_duty > i_pwm_cnt) : i_target;
        end
    end
endmodule

// File: rtl/led_fader.sv
// LED fader top: shared step prescaler and PWM counter feeding NUM_LEDS channels.
// Build with LED_FADER_GAMMA_EN defined for gamma-corrected duty.
module led_fader
    import led_fader_pkg::*;
#(
    parameter int NUM_LEDS = NUM_LEDS_DEF,
    parameter int PWM_BITS = PWM_BITS_DEF,
    parameter int STEP_DIV = STEP_DIV_DEF
) (
    input  logic         clk,
    input  logic         reset,
    led_fader_if.slave   bus
);
    localparam int                  SW        = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [SW-1:0]       STEP_LAST = SW'(STEP_DIV - 1);
    // PWM period is MAX cycles, so level MAX is on for every count.
    localparam logic [PWM_BITS-1:0] PWM_LAST  = PWM_BITS'(max_level(PWM_BITS) - 1);

    logic [SW-1:0]       r_step_cnt;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic                r_busy;
    logic                w_step_tick;
    logic [NUM_LEDS-1:0] w_mismatch;
    logic [NUM_LEDS-1:0] w_led;

    assign w_step_tick = (r_step_cnt == STEP_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_step_cnt <= '0;
            r_pwm_cnt  <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_step_cnt <= w_step_tick ? '0 : r_step_cnt + SW'(1);
            r_pwm_cnt  <= (r_pwm_cnt == PWM_LAST) ? '0 : r_pwm_cnt + PWM_BITS'(1);
            r_busy     <= |w_mismatch;
        end
    end

    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_ch
        led_fader_channel #(.PWM_BITS(PWM_BITS)) u_ch (
            .clk        (clk),
            .reset      (reset),
            .i_step_tick(w_step_tick),
            .i_pwm_cnt  (r_pwm_cnt),
            .i_target   (bus.led_in[g]),
            .i_fade_en  (bus.fade_en),
            .o_led      (w_led[g]),
            .o_mismatch (w_mismatch[g])
        );
    end

    assign bus.led_out = w_led;
    assign bus.busy    = r_busy;
endmodule

// File: tb/tb_led_fader.sv
// Scoreboard bench for led_fader: level/time model predicts led_out and busy each cycle.
// A second slow-stepping instance holds level 8 long enough to measure duty directly.
module tb_led_fader;
    localparam int NL   = 10;
    localparam int PB   = 4;
    localparam int SD   = 4;
    localparam int MAXV = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    led_fader_if #(.NUM_LEDS(NL)) bus ();
    led_fader_if #(.NUM_LEDS(NL)) bus2 ();

    led_fader #(.NUM_LEDS(NL), .PWM_BITS(PB), .STEP_DIV(SD)) dut (
        .clk(clk), .reset(rst), .bus(bus)
    );
    led_fader #(.NUM_LEDS(NL), .PWM_BITS(PB), .STEP_DIV(64)) dut2 (
        .clk(clk), .reset(rst), .bus(bus2)
    );

    int checks   = 0;
    int failures = 0;
    logic [NL:0] exp_q[$];
    int lvl[NL];
    int k;
    bit d2_done = 1'b0;

    function automatic int duty(input int l);
`ifdef LED_FADER_GAMMA_EN
        return (l == MAXV) ? MAXV : (l * l) >> PB;
`else
        return l;
`endif
    endfunction

    // Predict what the next clock edge produces, advance the model, then step one cycle.
    task automatic cycle();
        logic [NL-1:0] e_led;
        logic          e_busy;
        int            tgt;
        e_led  = '0;
        e_busy = 1'b0;
        if (rst) begin
            for (int i = 0; i < NL; i++) lvl[i] = 0;
            k = 0;
        end else begin
            for (int i = 0; i < NL; i++) begin
                tgt = bus.led_in[i] ? MAXV : 0;
                if (lvl[i] != tgt) e_busy = 1'b1;
                if (!bus.fade_en) begin
                    e_led[i] = bus.led_in[i];
                    lvl[i]   = tgt;
                end else begin
                    e_led[i] = (duty(lvl[i]) > (k % MAXV));
                    if ((k % SD) == SD - 1) begin
                        if (lvl[i] < tgt) lvl[i] = lvl[i] + 1;
                        else if (lvl[i] > tgt) lvl[i] = lvl[i] - 1;
                    end
                end
            end
            k = k + 1;
        end
        exp_q.push_back({e_busy, e_led});
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin : monitor
        logic [NL:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({bus.busy, bus.led_out} !== e) begin
                    failures++;
                    $display("FAIL scoreboard t=%0t got led_out=%h busy=%b want led_out=%h busy=%b",
                             $time, bus.led_out, bus.busy, e[NL-1:0], e[NL]);
                end
            end
        end
    end

    initial begin : duty_probe
        int hi;
        int want;
        bus2.led_in  = 10'h004;
        bus2.fade_en = 1'b1;
        want = duty(8);
        wait (rst == 1'b0);
        repeat (519) @(posedge clk);
        hi = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            hi += int'(bus2.led_out[2]);
        end
        checks++;
        if (hi != want) begin
            failures++;
            $display("FAIL duty_level8 high_cycles=%0d want=%0d", hi, want);
        end
        d2_done = 1'b1;
    end

    initial begin : stim
        int guard;
        rst         = 1'b1;
        bus.led_in  = '1;
        bus.fade_en = 1'b1;
        repeat (3) cycle();
        rst = 1'b0;
        repeat (8) cycle();
        bus.led_in = '0;
        repeat (70) cycle();
        // full ramp up on channel 0, then solid on
        bus.led_in = 10'h001;
        repeat (70) cycle();
        // channel 1 reverses at level 6
        bus.led_in = 10'h003;
        repeat (24) cycle();
        bus.led_in = 10'h001;
        repeat (30) cycle();
        // bypass, then fade down from snapped levels
        bus.fade_en = 1'b0;
        bus.led_in  = 10'h2A5;
        repeat (3) cycle();
        bus.fade_en = 1'b1;
        bus.led_in  = '0;
        repeat (70) cycle();
        repeat (120) begin
            bus.led_in  = NL'($urandom);
            bus.fade_en = ($urandom_range(0, 15) != 0);
            repeat ($urandom_range(1, 12)) cycle();
        end
        bus.fade_en = 1'b1;
        guard = 0;
        while (!d2_done && guard < 2000) begin
            cycle();
            guard++;
        end
        checks++;
        if (!d2_done) begin
            failures++;
            $display("FAIL duty_probe_timeout done=%0d want=1", d2_done);
        end
        // reset mid-ramp restarts from level 0
        bus.led_in = '1;
        repeat (30) cycle();
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        repeat (70) cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
